// File: rtl/inst_fetch_port.sv
// inst_fetch_port: responder side of the instruction-fetch interface.
// Takes pc/inst_en from the PC stage, runs a req/ack read on the instruction
// bus, returns the word to decode and holds the PC via stallreq while a fetch
// is in flight. Handles flush mid-fetch, bus timeout and misaligned pc.
// Optional macro IFP_LASTHIT_EN adds a one-entry last-address/word buffer
// that short-circuits a repeat fetch of the same address.
module inst_fetch_port #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_err,
  output logic        stallreq,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, DONE} state_e;

  state_e        state_q, state_d;
  logic          ibus_req_q, ibus_req_d;
  logic [31:0]   ibus_addr_q, ibus_addr_d;
  logic [31:0]   inst_q, inst_d;
  logic          inst_err_q, inst_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tmo;

`ifdef IFP_LASTHIT_EN
  logic          lh_vld_q, lh_vld_d;
  logic [31:0]   lh_addr_q, lh_addr_d;
  logic [31:0]   lh_data_q, lh_data_d;
  logic          lh_hit;

  assign lh_hit = lh_vld_q && (pc == lh_addr_q);
`endif

  // Timer has reached its last permitted cycle without an ack.
  assign tmo = (timer_q == TMAX) && !ibus_ack;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ibus_req_d  = ibus_req_q;
    ibus_addr_d = ibus_addr_q;
    inst_d      = inst_q;
    inst_err_d  = inst_err_q;
    timer_d     = timer_q;
`ifdef IFP_LASTHIT_EN
    lh_vld_d    = lh_vld_q;
    lh_addr_d   = lh_addr_q;
    lh_data_d   = lh_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (inst_en && !flush) begin
`ifdef IFP_LASTHIT_EN
          if (lh_hit) begin
            inst_d     = lh_data_q;
            inst_err_d = 1'b0;
            state_d    = DONE;
          end else
`endif
          if (pc[1:0] == 2'b00) begin
            ibus_addr_d = {pc[31:2], 2'b00};
            ibus_req_d  = 1'b1;
            timer_d     = '0;
            state_d     = REQ;
          end else begin
            // Misaligned: no bus cycle; the PC stage raises the exception.
            inst_d     = 32'h0;
            inst_err_d = 1'b0;
            state_d    = DONE;
          end
        end
      end
      REQ: begin
        timer_d = timer_q + 1'b1;
        if (ibus_ack) begin
          ibus_req_d = 1'b0;
          if (!flush) begin
            inst_d     = ibus_rdata;
            inst_err_d = 1'b0;
            state_d    = DONE;
`ifdef IFP_LASTHIT_EN
            lh_vld_d   = 1'b1;
            lh_addr_d  = ibus_addr_q;
            lh_data_d  = ibus_rdata;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == TMAX) begin
          ibus_req_d = 1'b0;
          inst_d     = 32'h0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            inst_err_d = 1'b1;
            state_d    = DONE;
          end
        end else if (flush) begin
          // Request stays up until the slave acks or we time out.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        timer_d = timer_q + 1'b1;
        if (ibus_ack || timer_q == TMAX) begin
          ibus_req_d = 1'b0;
          state_d    = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef IFP_LASTHIT_EN
    // Flush or a timeout invalidates the buffered word.
    if (flush || ((state_q == REQ || state_q == DISCARD) && tmo))
      lh_vld_d = 1'b0;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ibus_req_q  <= 1'b0;
      ibus_addr_q <= 32'h0;
      inst_q      <= 32'h0;
      inst_err_q  <= 1'b0;
      timer_q     <= '0;
`ifdef IFP_LASTHIT_EN
      lh_vld_q    <= 1'b0;
      lh_addr_q   <= 32'h0;
      lh_data_q   <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      ibus_req_q  <= ibus_req_d;
      ibus_addr_q <= ibus_addr_d;
      inst_q      <= inst_d;
      inst_err_q  <= inst_err_d;
      timer_q     <= timer_d;
`ifdef IFP_LASTHIT_EN
      lh_vld_q    <= lh_vld_d;
      lh_addr_q   <= lh_addr_d;
      lh_data_q   <= lh_data_d;
`endif
    end
  end

  // Stall and valid are decoded from the current state.
  always_comb begin
    stallreq = 1'b0;
    unique case (state_q)
      IDLE:         stallreq = inst_en && !flush;
      REQ, DISCARD: stallreq = 1'b1;
      default:      stallreq = 1'b0;
    endcase
  end

  assign inst_valid = (state_q == DONE) && !flush;
  assign inst       = inst_q;
  assign inst_err   = inst_err_q;
  assign ibus_req   = ibus_req_q;
  assign ibus_addr  = ibus_addr_q;

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed bench for inst_fetch_port (TIMEOUT_CYC=4).
module tb_inst_fetch_port;
  logic        clk = 1'b0;
  logic        rst, inst_en, flush, ibus_ack;
  logic [31:0] pc, ibus_rdata;
  logic [31:0] inst, ibus_addr;
  logic        inst_valid, inst_err, stallreq, ibus_req;
  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_port #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .inst_en(inst_en), .pc(pc), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .inst_err(inst_err),
    .stallreq(stallreq), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch: request at c0, ack in first REQ cycle, check DONE.
  task automatic fetch0(input logic [31:0] a, input logic [31:0] d);
    inst_en = 1'b1; pc = a;
    tick;
    inst_en = 1'b0; ibus_ack = 1'b1; ibus_rdata = d;
    #1;
    chk("f0_req", 32'(ibus_req), 1);
    chk("f0_addr", ibus_addr, a);
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("f0_valid", 32'(inst_valid), 1);
    chk("f0_inst", inst, d);
    tick;
  endtask

  initial begin
    rst = 1'b1; inst_en = 1'b0; flush = 1'b0; ibus_ack = 1'b0;
    pc = 32'h0; ibus_rdata = 32'h0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(ibus_req), 0);
    chk("rst_addr", ibus_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_err", 32'(inst_err), 0);
    chk("rst_stall", 32'(stallreq), 0);

    // Zero-wait fetch with cycle-by-cycle stall/valid checks.
    inst_en = 1'b1; pc = 32'hBFC00000;
    #1;
    chk("zw_c0_stall", 32'(stallreq), 1);
    chk("zw_c0_req", 32'(ibus_req), 0);
    tick;
    inst_en = 1'b0; ibus_ack = 1'b1; ibus_rdata = 32'h3C1D8000;
    #1;
    chk("zw_c1_req", 32'(ibus_req), 1);
    chk("zw_c1_addr", ibus_addr, 32'hBFC00000);
    chk("zw_c1_stall", 32'(stallreq), 1);
    chk("zw_c1_valid", 32'(inst_valid), 0);
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("zw_c2_valid", 32'(inst_valid), 1);
    chk("zw_c2_inst", inst, 32'h3C1D8000);
    chk("zw_c2_err", 32'(inst_err), 0);
    chk("zw_c2_stall", 32'(stallreq), 0);
    chk("zw_c2_req", 32'(ibus_req), 0);
    tick;
    chk("zw_c3_valid", 32'(inst_valid), 0);

    // Three wait states: ack on the 4th REQ cycle (coincides with timer limit).
    inst_en = 1'b1; pc = 32'hBFC00004;
    #1;
    chk("ws_c0_stall", 32'(stallreq), 1);
    tick;
    inst_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("ws_req", 32'(ibus_req), 1);
      chk("ws_addr", ibus_addr, 32'hBFC00004);
      chk("ws_stall", 32'(stallreq), 1);
      chk("ws_valid", 32'(inst_valid), 0);
      tick;
    end
    ibus_ack = 1'b1; ibus_rdata = 32'h12345678;
    #1;
    chk("ws_c4_req", 32'(ibus_req), 1);
    chk("ws_c4_stall", 32'(stallreq), 1);
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("ws_c5_valid", 32'(inst_valid), 1);
    chk("ws_c5_inst", inst, 32'h12345678);
    chk("ws_c5_err", 32'(inst_err), 0);
    chk("ws_c5_stall", 32'(stallreq), 0);
    tick;

    // Reset while in REQ clears everything at the next edge.
    inst_en = 1'b1; pc = 32'hBFC00300;
    tick;
    inst_en = 1'b0;
    #1;
    chk("rq_req", 32'(ibus_req), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rq_req0", 32'(ibus_req), 0);
    chk("rq_addr0", ibus_addr, 0);
    chk("rq_inst0", inst, 0);
    chk("rq_valid0", 32'(inst_valid), 0);
    chk("rq_stall0", 32'(stallreq), 0);

    // Flush during REQ; ack two cycles later is dropped.
    inst_en = 1'b1; pc = 32'hBFC00100;
    tick;
    inst_en = 1'b0; flush = 1'b1;
    #1;
    chk("fl_c1_req", 32'(ibus_req), 1);
    chk("fl_c1_valid", 32'(inst_valid), 0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_c2_req", 32'(ibus_req), 1);
    chk("fl_c2_stall", 32'(stallreq), 1);
    tick;
    ibus_ack = 1'b1; ibus_rdata = 32'hDEADBEEF;
    #1;
    chk("fl_c3_req", 32'(ibus_req), 1);
    chk("fl_c3_valid", 32'(inst_valid), 0);
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("fl_c4_req", 32'(ibus_req), 0);
    chk("fl_c4_valid", 32'(inst_valid), 0);
    chk("fl_c4_stall", 32'(stallreq), 0);
    fetch0(32'hBFC00380, 32'h0000000F);

    // Timeout: no ack; 4 REQ cycles then DONE with err.
    inst_en = 1'b1; pc = 32'hBFC00200;
    tick;
    inst_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("to_req", 32'(ibus_req), 1);
      chk("to_valid", 32'(inst_valid), 0);
      tick;
    end
    #1;
    chk("to_req0", 32'(ibus_req), 0);
    chk("to_valid", 32'(inst_valid), 1);
    chk("to_err", 32'(inst_err), 1);
    chk("to_inst", inst, 0);
    tick;
    chk("to_after_valid", 32'(inst_valid), 0);

    // Misaligned pc: no bus cycle, DONE next cycle with inst=0, err cleared.
    inst_en = 1'b1; pc = 32'hBFC00002;
    #1;
    chk("ma_stall", 32'(stallreq), 1);
    tick;
    inst_en = 1'b0;
    #1;
    chk("ma_req", 32'(ibus_req), 0);
    chk("ma_valid", 32'(inst_valid), 1);
    chk("ma_inst", inst, 0);
    chk("ma_err", 32'(inst_err), 0);
    // Flush in DONE masks inst_valid combinationally.
    flush = 1'b1;
    #1;
    chk("done_flush_valid", 32'(inst_valid), 0);
    tick;
    flush = 1'b0;

    // Last-address buffer: repeat fetch of a just-completed address.
    fetch0(32'hBFC00000, 32'h3C1D8000);
    inst_en = 1'b1; pc = 32'hBFC00000;
    tick;
    inst_en = 1'b0;
    #1;
`ifdef IFP_LASTHIT_EN
    chk("lh_req", 32'(ibus_req), 0);
    chk("lh_valid", 32'(inst_valid), 1);
    chk("lh_inst", inst, 32'h3C1D8000);
    tick;
`else
    chk("lh_req", 32'(ibus_req), 1);
    ibus_ack = 1'b1; ibus_rdata = 32'h3C1D8000;
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("lh_valid", 32'(inst_valid), 1);
    chk("lh_inst", inst, 32'h3C1D8000);
    tick;
`endif
    // After a flush the same address must go to the bus.
    flush = 1'b1;
    tick;
    flush = 1'b0;
    inst_en = 1'b1; pc = 32'hBFC00000;
    tick;
    inst_en = 1'b0;
    #1;
    chk("lhf_req", 32'(ibus_req), 1);
    chk("lhf_valid", 32'(inst_valid), 0);
    ibus_ack = 1'b1; ibus_rdata = 32'h3C1D8001;
    tick;
    ibus_ack = 1'b0;
    #1;
    chk("lhf_valid1", 32'(inst_valid), 1);
    chk("lhf_inst", inst, 32'h3C1D8001);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
